// File: rtl/maxpool_layer_responder.sv
// Max-pool layer endpoint for the scheduler's start/done handshake and inter-layer copy.
// Sweeps a KxK signed max-pool over the input buffer and exposes the result combinationally.
module maxpool_layer_responder #(
  parameter int DATA_SIZE  = 64,
  parameter int NUM_CH     = 16,
  parameter int IN_DIM     = 26,
  parameter int KERNEL_DIM = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 compute_start,
  output logic                 compute_done,
  input  logic                 inmem_wantwrite,
  input  logic [15:0]          inmem_index0,
  input  logic [15:0]          inmem_index1,
  input  logic [15:0]          inmem_index2,
  input  logic [DATA_SIZE-1:0] inmem_wdata,
  input  logic [15:0]          outmem_index0,
  input  logic [15:0]          outmem_index1,
  input  logic [15:0]          outmem_index2,
  output logic [DATA_SIZE-1:0] outmem_rdata,
  output logic                 wr_conflict
);

  localparam int OUT_DIM = IN_DIM / KERNEL_DIM;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int KW = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;

  logic [DATA_SIZE-1:0] in_mem  [NUM_CH][IN_DIM][IN_DIM];
  logic [DATA_SIZE-1:0] out_mem [NUM_CH][OUT_DIM][OUT_DIM];

  logic [KW-1:0] kx, ky;
  logic [OW-1:0] x, y;
  logic [CW-1:0] c;
  logic          draining;

  logic [DATA_SIZE-1:0] run_max, elem, next_max;
  logic [IW-1:0]        row_addr, col_addr;
  logic                 first_elem, kx_last, ky_last, x_last, y_last, c_last;
  logic                 in_wr_ok, out_we, rd_ok;

  assign row_addr = IW'(int'(y) * KERNEL_DIM + int'(ky));
  assign col_addr = IW'(int'(x) * KERNEL_DIM + int'(kx));
  assign elem     = in_mem[c][row_addr][col_addr];

  assign first_elem = (kx == '0) && (ky == '0);
  assign kx_last    = (kx == KW'(KERNEL_DIM - 1));
  assign ky_last    = (ky == KW'(KERNEL_DIM - 1));
  assign x_last     = (x == OW'(OUT_DIM - 1));
  assign y_last     = (y == OW'(OUT_DIM - 1));
  assign c_last     = (c == CW'(NUM_CH - 1));

  // Strict greater-than keeps the running value on ties.
  assign next_max = first_elem ? elem :
                    (($signed(elem) > $signed(run_max)) ? elem : run_max);

  assign in_wr_ok = inmem_wantwrite && (state != BUSY) &&
                    (inmem_index0 < 16'(IN_DIM)) &&
                    (inmem_index1 < 16'(IN_DIM)) &&
                    (inmem_index2 < 16'(NUM_CH));

  assign out_we = (state == BUSY) && !draining && kx_last && ky_last && !reset;

  // The extra draining cycle after the last element sets the start-to-done latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      compute_done <= 1'b0;
      wr_conflict  <= 1'b0;
      kx           <= '0;
      ky           <= '0;
      x            <= '0;
      y            <= '0;
      c            <= '0;
      draining     <= 1'b0;
      run_max      <= '0;
    end else begin
      if (inmem_wantwrite && (state == BUSY))
        wr_conflict <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (compute_start) begin
            state        <= BUSY;
            compute_done <= 1'b0;
            kx           <= '0;
            ky           <= '0;
            x            <= '0;
            y            <= '0;
            c            <= '0;
            draining     <= 1'b0;
          end
        end
        BUSY: begin
          if (draining) begin
            state        <= DONE;
            compute_done <= 1'b1;
            draining     <= 1'b0;
          end else begin
            run_max <= next_max;
            if (!kx_last) begin
              kx <= kx + 1'b1;
            end else begin
              kx <= '0;
              if (!ky_last) begin
                ky <= ky + 1'b1;
              end else begin
                ky <= '0;
                if (!x_last) begin
                  x <= x + 1'b1;
                end else begin
                  x <= '0;
                  if (!y_last) begin
                    y <= y + 1'b1;
                  end else begin
                    y <= '0;
                    if (!c_last) begin
                      c <= c + 1'b1;
                    end else begin
                      c        <= '0;
                      draining <= 1'b1;
                    end
                  end
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_wr_ok)
      in_mem[inmem_index2[CW-1:0]][inmem_index1[IW-1:0]][inmem_index0[IW-1:0]] <= inmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (out_we)
      out_mem[c][y][x] <= next_max;
  end

  assign rd_ok = (outmem_index0 < 16'(OUT_DIM)) &&
                 (outmem_index1 < 16'(OUT_DIM)) &&
                 (outmem_index2 < 16'(NUM_CH));

  always_comb begin
    outmem_rdata = '0;
    if (rd_ok)
      outmem_rdata = out_mem[outmem_index2[CW-1:0]][outmem_index1[OW-1:0]][outmem_index0[OW-1:0]];
  end

endmodule

// File: tb/tb_maxpool_layer_responder.sv
// Directed bench for maxpool_layer_responder: small 2ch/4x4/K=2 instance plus a default-size latency run.
module tb_maxpool_layer_responder;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          compute_start;
  logic          compute_done;
  logic          inmem_wantwrite;
  logic [15:0]   inmem_index0, inmem_index1, inmem_index2;
  logic [DW-1:0] inmem_wdata;
  logic [15:0]   outmem_index0, outmem_index1, outmem_index2;
  logic [DW-1:0] outmem_rdata;
  logic          wr_conflict;

  logic          start_def;
  logic          done_def;
  logic [63:0]   rdata_def;
  logic          conflict_def;

  int checks;
  int errors;
  int lat;

  typedef struct {
    string       name;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] i2;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [11];

  maxpool_layer_responder #(
    .DATA_SIZE(DW), .NUM_CH(2), .IN_DIM(4), .KERNEL_DIM(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .compute_start(compute_start),
    .compute_done(compute_done),
    .inmem_wantwrite(inmem_wantwrite),
    .inmem_index0(inmem_index0),
    .inmem_index1(inmem_index1),
    .inmem_index2(inmem_index2),
    .inmem_wdata(inmem_wdata),
    .outmem_index0(outmem_index0),
    .outmem_index1(outmem_index1),
    .outmem_index2(outmem_index2),
    .outmem_rdata(outmem_rdata),
    .wr_conflict(wr_conflict)
  );

  maxpool_layer_responder dut_def (
    .clk(clk),
    .reset(reset),
    .compute_start(start_def),
    .compute_done(done_def),
    .inmem_wantwrite(1'b0),
    .inmem_index0(16'd0),
    .inmem_index1(16'd0),
    .inmem_index2(16'd0),
    .inmem_wdata(64'd0),
    .outmem_index0(16'd0),
    .outmem_index1(16'd0),
    .outmem_index2(16'd0),
    .outmem_rdata(rdata_def),
    .wr_conflict(conflict_def)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] yy,
                               input logic [15:0] ch, input logic [DW-1:0] d);
    @(negedge clk);
    inmem_wantwrite = 1'b1;
    inmem_index0    = x;
    inmem_index1    = yy;
    inmem_index2    = ch;
    inmem_wdata     = d;
    @(posedge clk);
    #1 inmem_wantwrite = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    compute_start = 1'b1;
    @(posedge clk);
    #1 compute_start = 1'b0;
  endtask

  // Counts edges after the start edge; optionally injects a start, a write or a reset at edge i.
  task automatic wait_done(input int start_at, input int write_at, input int reset_at,
                           output int latency);
    latency = -1;
    for (int i = 1; i <= 200; i++) begin
      compute_start   = (i == start_at);
      reset           = (i == reset_at);
      inmem_wantwrite = (i == write_at);
      inmem_index0    = 16'd0;
      inmem_index1    = 16'd0;
      inmem_index2    = 16'd0;
      inmem_wdata     = 16'd100;
      @(posedge clk);
      #1;
      compute_start   = 1'b0;
      reset           = 1'b0;
      inmem_wantwrite = 1'b0;
      if (i == reset_at) begin
        latency = 0;
        break;
      end
      if (compute_done) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      outmem_index0 = tbl[i].i0;
      outmem_index1 = tbl[i].i1;
      outmem_index2 = tbl[i].i2;
      #1;
      checkOutput({tag, "_", tbl[i].name}, 64'(outmem_rdata), 64'(tbl[i].exp));
    end
  endtask

  task automatic check_read(input string name, input logic [15:0] x, input logic [15:0] yy,
                            input logic [15:0] ch, input logic [DW-1:0] exp);
    outmem_index0 = x;
    outmem_index1 = yy;
    outmem_index2 = ch;
    #1;
    checkOutput(name, 64'(outmem_rdata), 64'(exp));
  endtask

  initial begin
    tbl[0]  = '{"c0_00", 16'd0, 16'd0, 16'd0, 16'd5};
    tbl[1]  = '{"c0_10", 16'd1, 16'd0, 16'd0, 16'd7};
    tbl[2]  = '{"c0_01", 16'd0, 16'd1, 16'd0, 16'd13};
    tbl[3]  = '{"c0_11", 16'd1, 16'd1, 16'd0, 16'd15};
    tbl[4]  = '{"c1_00", 16'd0, 16'd0, 16'd1, 16'hffff};
    tbl[5]  = '{"c1_10", 16'd1, 16'd0, 16'd1, 16'hfffd};
    tbl[6]  = '{"c1_01", 16'd0, 16'd1, 16'd1, 16'hfff7};
    tbl[7]  = '{"c1_11", 16'd1, 16'd1, 16'd1, 16'hfff5};
    tbl[8]  = '{"oor_row", 16'd0, 16'd2, 16'd0, 16'd0};
    tbl[9]  = '{"oor_col", 16'd2, 16'd0, 16'd1, 16'd0};
    tbl[10] = '{"oor_ch", 16'd0, 16'd0, 16'd2, 16'd0};

    checks = 0;
    errors = 0;
    reset = 1'b1;
    compute_start = 1'b0;
    start_def = 1'b0;
    inmem_wantwrite = 1'b0;
    inmem_index0 = '0;
    inmem_index1 = '0;
    inmem_index2 = '0;
    inmem_wdata = '0;
    outmem_index0 = '0;
    outmem_index1 = '0;
    outmem_index2 = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", 64'(compute_done), 64'd0);
    checkOutput("reset_conflict", 64'(wr_conflict), 64'd0);
    @(negedge clk) reset = 1'b0;

    // ch1 (0,0) starts with a dummy value that the start-cycle write must replace.
    for (int yy = 0; yy < 4; yy++) begin
      for (int x = 0; x < 4; x++) begin
        applyStimulus(16'(x), 16'(yy), 16'd0, 16'(yy * 4 + x));
        applyStimulus(16'(x), 16'(yy), 16'd1,
                      (x == 0 && yy == 0) ? 16'd77 : 16'(-(yy * 4 + x) - 1));
      end
    end
    applyStimulus(16'd4, 16'd0, 16'd0, 16'd99);
    applyStimulus(16'd0, 16'd4, 16'd0, 16'd98);
    applyStimulus(16'd1, 16'd1, 16'd2, 16'd500);
    checkOutput("oor_write_conflict", 64'(wr_conflict), 64'd0);

    // Run A: write in the start cycle, stray start at BUSY cycle 10.
    @(negedge clk);
    compute_start   = 1'b1;
    inmem_wantwrite = 1'b1;
    inmem_index0    = 16'd0;
    inmem_index1    = 16'd0;
    inmem_index2    = 16'd1;
    inmem_wdata     = 16'hffff;
    @(posedge clk);
    #1;
    compute_start   = 1'b0;
    inmem_wantwrite = 1'b0;
    checkOutput("runA_done_low", 64'(compute_done), 64'd0);
    wait_done(10, 0, 0, lat);
    checkOutput("runA_latency", 64'(lat), 64'd33);
    checkOutput("runA_conflict", 64'(wr_conflict), 64'd0);
    check_table("runA");

    // Run B: restart from DONE with a write attempted mid-sweep.
    pulse_start();
    checkOutput("runB_done_drop", 64'(compute_done), 64'd0);
    wait_done(0, 5, 0, lat);
    checkOutput("runB_latency", 64'(lat), 64'd33);
    checkOutput("runB_conflict", 64'(wr_conflict), 64'd1);
    check_table("runB");
    repeat (5) @(posedge clk);
    #1 checkOutput("runB_conflict_sticky", 64'(wr_conflict), 64'd1);

    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_conflict_clear", 64'(wr_conflict), 64'd0);
    checkOutput("rst_done_clear", 64'(compute_done), 64'd0);

    applyStimulus(16'd0, 16'd0, 16'd0, 16'hfffb);
    applyStimulus(16'd1, 16'd0, 16'd0, 16'hfffe);
    applyStimulus(16'd0, 16'd1, 16'd0, 16'hfff9);
    applyStimulus(16'd1, 16'd1, 16'd0, 16'hfffe);
    applyStimulus(16'd2, 16'd0, 16'd0, 16'h8000);
    applyStimulus(16'd3, 16'd0, 16'd0, 16'h8000);
    applyStimulus(16'd2, 16'd1, 16'd0, 16'h8000);
    applyStimulus(16'd3, 16'd1, 16'd0, 16'h8000);

    // Run C: abort by reset at BUSY cycle 12, then a clean run.
    pulse_start();
    wait_done(0, 0, 12, lat);
    checkOutput("abort_done_low", 64'(compute_done), 64'd0);
    checkOutput("abort_reached", 64'(lat), 64'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("abort_stays_idle", 64'(compute_done), 64'd0);
    pulse_start();
    wait_done(0, 0, 0, lat);
    checkOutput("runC_latency", 64'(lat), 64'd33);
    check_read("runC_ties_neg", 16'd0, 16'd0, 16'd0, 16'hfffe);
    check_read("runC_all_min", 16'd1, 16'd0, 16'd0, 16'h8000);
    check_read("runC_c0_01", 16'd0, 16'd1, 16'd0, 16'd13);
    check_read("runC_c1_00", 16'd0, 16'd0, 16'd1, 16'hffff);

    // Default-size instance only checks the start-to-done latency.
    @(negedge clk) start_def = 1'b1;
    @(posedge clk);
    #1 start_def = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12000; i++) begin
      @(posedge clk);
      #1;
      if (done_def) begin
        lat = i;
        break;
      end
    end
    checkOutput("default_latency", 64'(lat), 64'd10817);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
